// File: rtl/vision_pkg.sv
// Shared definitions for the vision-tester sequencer.
//   state_t     : trial-loop FSM states
//   SYM_*       : glyph selector codes understood by the matrix stage
//   LFSR_SEED   : power-up value of the orientation LFSR
//   lfsr_step() : one step of the x^4+x^3+1 Fibonacci LFSR
package vision_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHOW,
    JUDGE,
    FEEDBACK,
    DONE
  } state_t;

  localparam logic [3:0] SYM_UP    = 4'd0;
  localparam logic [3:0] SYM_DOWN  = 4'd1;
  localparam logic [3:0] SYM_LEFT  = 4'd2;
  localparam logic [3:0] SYM_RIGHT = 4'd3;
  localparam logic [3:0] SYM_OK    = 4'd4;
  localparam logic [3:0] SYM_BLANK = 4'd8;

  localparam logic [3:0] LFSR_SEED = 4'b1001;

  // Shift left, feedback from the x^4 and x^3 taps; maximal length (15 states).
  function automatic logic [3:0] lfsr_step(input logic [3:0] v);
    return {v[2:0], v[3] ^ v[2]};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner.
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   btn_raw  in  raw asynchronous button level, active-high
//   rise     out one-cycle pulse when the debounced level goes 0 -> 1
// The raw input is synchronised by two flops; the debounced level only
// follows the synchronised input after it has differed from the current
// level for DEB_CNT consecutive cycles.
module btn_debounce #(
  parameter int DEB_CNT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic rise
);

  localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          meta_reg;
  logic          sync_reg;
  logic          level_reg;
  logic          rise_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg  <= 1'b0;
      sync_reg  <= 1'b0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      meta_reg <= btn_raw;
      sync_reg <= meta_reg;
      rise_reg <= 1'b0;
      if (sync_reg == level_reg) begin
        // Any return to the accepted level restarts the stability window.
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        level_reg <= sync_reg;
        rise_reg  <= sync_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/vision_test_seq.sv
// Upstream sequencer for the 8x8 LED-matrix vision tester.
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   start     in   one-cycle request to begin a test (honoured in IDLE only)
//   btn[3:0]  in   raw buttons {up,down,left,right}, active-high
//   scan_idx  out  row index 0..7 for the matrix stage
//   sym_sel   out  glyph: 0..3 optotype, 4 OK, 8 blank
//   score     out  correct answers of the current/last test
//   busy      out  test in progress
//   done      out  one-cycle pulse at the end of the last feedback
// A free-running row divider produces row/frame ticks used as the only
// timebase for answer timeout and feedback duration.  A trial shows a
// random optotype, waits for a single debounced press (or timeout), grades
// it and shows feedback.  All outputs are registered from the current state,
// so they follow a state change by one cycle.
module vision_test_seq
  import vision_pkg::*;
#(
  parameter int SCAN_DIV    = 6250,
  parameter int DEB_CNT     = 1000000,
  parameter int TIMEOUT_FRM = 3000,
  parameter int FB_FRM      = 500,
  parameter int NUM_TRIALS  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [2:0] scan_idx,
  output logic [3:0] sym_sel,
  output logic [2:0] score,
  output logic       busy,
  output logic       done
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam int FRM_MAX = (TIMEOUT_FRM > FB_FRM) ? TIMEOUT_FRM : FB_FRM;
  localparam int FRM_W   = $clog2(FRM_MAX + 1);
  localparam logic [FRM_W-1:0] TIMEOUT_LAST = FRM_W'(TIMEOUT_FRM);
  localparam logic [FRM_W-1:0] FB_LAST      = FRM_W'(FB_FRM);
  localparam logic [FRM_W-1:0] FRM_ONE      = FRM_W'(1);

  localparam logic [2:0] TRIALS_LAST = 3'(NUM_TRIALS);

  // ---------------------------------------------------------------- scan
  logic [DIV_W-1:0] div_reg;
  logic [2:0]       scan_idx_reg;
  logic             row_tick;
  logic             frame_tick;

  assign row_tick   = (div_reg == DIV_LAST);
  assign frame_tick = row_tick && (scan_idx_reg == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg      <= '0;
      scan_idx_reg <= 3'd0;
    end else begin
      div_reg <= row_tick ? '0 : div_reg + DIV_ONE;
      if (row_tick) begin
        scan_idx_reg <= scan_idx_reg + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------- LFSR
  logic [3:0] lfsr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= lfsr_step(lfsr_reg);
    end
  end

  // ------------------------------------------------------------- buttons
  // press[i] is the rising edge for glyph code i; btn is ordered
  // {up,down,left,right}, so glyph i maps to btn[3-i].
  logic [3:0] press;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      btn_debounce #(
        .DEB_CNT(DEB_CNT)
      ) u_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn[3-gi]),
        .rise   (press[gi])
      );
    end
  endgenerate

  // ----------------------------------------------------------------- FSM
  state_t           state_reg,   state_next;
  logic [1:0]       orient_reg;
  logic             hit_reg,     hit_next;
  logic [2:0]       score_reg,   score_next;
  logic [2:0]       trial_reg,   trial_next;
  logic [FRM_W-1:0] frame_reg;
  logic [3:0]       sym_sel_reg, sym_sel_next;
  logic             busy_reg,    busy_next;
  logic             done_reg,    done_next;
  logic [3:0]       orient_mask;

  assign orient_mask = 4'b0001 << orient_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    hit_next     = hit_reg;
    score_next   = score_reg;
    trial_next   = trial_reg;
    sym_sel_next = sym_sel_reg;
    busy_next    = 1'b0;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        sym_sel_next = SYM_BLANK;
        if (start) begin
          state_next = SHOW;
          score_next = 3'd0;
          trial_next = 3'd0;
        end
      end
      SHOW: begin
        sym_sel_next = {2'b00, orient_reg};
        busy_next    = 1'b1;
        if (press != 4'b0000) begin
          // Correct only if exactly the orientation's button rose; any
          // multi-button press fails this one-hot comparison.  A press in
          // the timeout cycle takes this branch, so the press wins.
          state_next = JUDGE;
          hit_next   = (press == orient_mask);
        end else if (frame_reg == TIMEOUT_LAST) begin
          state_next = JUDGE;
          hit_next   = 1'b0;
        end
      end
      JUDGE: begin
        busy_next  = 1'b1;
        state_next = FEEDBACK;
        if (hit_reg && (score_reg != TRIALS_LAST)) begin
          score_next = score_reg + 3'd1;
        end
      end
      FEEDBACK: begin
        sym_sel_next = hit_reg ? SYM_OK : SYM_BLANK;
        busy_next    = 1'b1;
        if (frame_reg == FB_LAST) begin
          trial_next = trial_reg + 3'd1;
          state_next = (trial_reg + 3'd1 == TRIALS_LAST) ? DONE : SHOW;
        end
      end
      DONE: begin
        sym_sel_next = SYM_BLANK;
        done_next    = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Counters, orientation capture and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orient_reg  <= 2'd0;
      hit_reg     <= 1'b0;
      score_reg   <= 3'd0;
      trial_reg   <= 3'd0;
      frame_reg   <= '0;
      sym_sel_reg <= SYM_BLANK;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      hit_reg     <= hit_next;
      score_reg   <= score_next;
      trial_reg   <= trial_next;
      sym_sel_reg <= sym_sel_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      if ((state_next == SHOW) && (state_reg != SHOW)) begin
        orient_reg <= lfsr_reg[1:0];
      end
      // Frame count restarts on every state change, so a frame tick on the
      // entry edge itself is not counted.
      if (state_next != state_reg) begin
        frame_reg <= '0;
      end else if (frame_tick && ((state_reg == SHOW) || (state_reg == FEEDBACK))) begin
        frame_reg <= frame_reg + FRM_ONE;
      end
    end
  end

  assign scan_idx = scan_idx_reg;
  assign sym_sel  = sym_sel_reg;
  assign score    = score_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_vision_test_seq.sv
// Directed bench for vision_test_seq with a 4-clk row, 32-clk frame,
// 8-clk debounce, 10-frame timeout, 3-frame feedback and 3 trials.
module tb_vision_test_seq;

  localparam int WAIT_MAX = 2000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] btn;
  logic [2:0] scan_idx;
  logic [3:0] sym_sel;
  logic [2:0] score;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  vision_test_seq #(
    .SCAN_DIV   (4),
    .DEB_CNT    (8),
    .TIMEOUT_FRM(10),
    .FB_FRM     (3),
    .NUM_TRIALS (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .btn     (btn),
    .scan_idx(scan_idx),
    .sym_sel (sym_sel),
    .score   (score),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------ stimulus helpers
  function automatic logic [3:0] btn_for(input logic [3:0] s);
    logic [3:0] v;
    v = 4'b1000 >> s[1:0];
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic press_for(input logic [3:0] bits, input int n);
    btn = bits;
    repeat (n) tick();
    btn = 4'b0000;
  endtask

  task automatic wait_show(output logic [3:0] o, output bit ok);
    ok = 1'b0;
    o  = 4'd8;
    for (int i = 0; i < WAIT_MAX; i++) begin
      if (sym_sel < 4'd4) begin
        o  = sym_sel;
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic run_len(input logic [3:0] v, output int n);
    n = 0;
    while ((sym_sel == v) && (n < WAIT_MAX)) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_done(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < WAIT_MAX) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
      n++;
    end
  endtask

  // ------------------------------------------------------------- scenarios
  task automatic test_reset();
    logic [2:0] exp_idx;
    rst_n = 1'b0; start = 1'b0; btn = 4'b0000;
    tick(); tick();
    checks++; if (scan_idx !== 3'd0)  begin errors++; $display("FAIL rst_scan_idx: got %0d expected 0", scan_idx); end
    checks++; if (sym_sel !== 4'd8)   begin errors++; $display("FAIL rst_sym_sel: got %0d expected 8", sym_sel); end
    checks++; if (score !== 3'd0)     begin errors++; $display("FAIL rst_score: got %0d expected 0", score); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %0d expected 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL rst_done: got %0d expected 0", done); end
    rst_n = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      tick();
      exp_idx = 3'((c / 4) % 8);
      checks++; if (scan_idx !== exp_idx) begin errors++; $display("FAIL scan_step c=%0d: got %0d expected %0d", c, scan_idx, exp_idx); end
      checks++; if (sym_sel !== 4'd8 || busy !== 1'b0) begin errors++; $display("FAIL idle_out c=%0d: got sym %0d busy %0d expected sym 8 busy 0", c, sym_sel, busy); end
    end
    $display("test_reset: scan stepped through 36 cycles");
  endtask

  task automatic test_correct();
    logic [3:0] o;
    bit ok;
    int n;
    pulse_start();
    for (int t = 0; t < 3; t++) begin
      wait_show(o, ok);
      checks++; if (!ok) begin errors++; $display("FAIL corr_show t=%0d: got timeout expected optotype", t); end
      checks++; if (busy !== 1'b1 || score !== 3'(t)) begin errors++; $display("FAIL corr_pre t=%0d: got busy %0d score %0d expected busy 1 score %0d", t, busy, score, t); end
      press_for(btn_for(o), 12);
      run_len(o, n);
      checks++; if (sym_sel !== 4'd4) begin errors++; $display("FAIL corr_fb t=%0d: got %0d expected 4", t, sym_sel); end
      checks++; if (score !== 3'(t + 1)) begin errors++; $display("FAIL corr_score t=%0d: got %0d expected %0d", t, score, t + 1); end
      run_len(4'd4, n);
      checks++; if (n < 66 || n > 97) begin errors++; $display("FAIL corr_fb_len t=%0d: got %0d expected 66..97", t, n); end
      if (t == 2) begin
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL corr_done: got done %0d busy %0d expected done 1 busy 0", done, busy); end
        tick();
        checks++; if (done !== 1'b0 || sym_sel !== 4'd8) begin errors++; $display("FAIL corr_done_pulse: got done %0d sym %0d expected done 0 sym 8", done, sym_sel); end
      end else begin
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL corr_no_done t=%0d: got %0d expected 0", t, done); end
      end
      $display("test_correct: trial %0d orient %0d score %0d fb_len %0d", t, o, score, n);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] o;
    bit ok;
    int n;
    pulse_start();
    for (int t = 0; t < 3; t++) begin
      wait_show(o, ok);
      checks++; if (!ok) begin errors++; $display("FAIL to_show t=%0d: got timeout expected optotype", t); end
      run_len(o, n);
      checks++; if (n < 291 || n > 322) begin errors++; $display("FAIL to_show_len t=%0d: got %0d expected 291..322", t, n); end
      checks++; if (sym_sel !== 4'd8) begin errors++; $display("FAIL to_fb t=%0d: got %0d expected 8", t, sym_sel); end
      checks++; if (score !== 3'd0) begin errors++; $display("FAIL to_score t=%0d: got %0d expected 0", t, score); end
      if (t < 2) begin
        run_len(4'd8, n);
        checks++; if (n < 66 || n > 97) begin errors++; $display("FAIL to_fb_len t=%0d: got %0d expected 66..97", t, n); end
      end else begin
        wait_done(n, ok);
        checks++; if (!ok || n < 65 || n > 96) begin errors++; $display("FAIL to_done: got ok %0d after %0d expected ok 1 after 65..96", ok, n); end
        checks++; if (score !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL to_end: got score %0d busy %0d expected 0 0", score, busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL to_done_pulse: got %0d expected 0", done); end
      end
      $display("test_timeout: trial %0d orient %0d score %0d", t, o, score);
    end
  endtask

  task automatic test_multi_glitch();
    logic [3:0] o;
    bit ok;
    int n;
    pulse_start();
    wait_show(o, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mg_show: got timeout expected optotype"); end
    press_for(btn_for(o), 5);
    repeat (20) tick();
    checks++; if (sym_sel !== o) begin errors++; $display("FAIL mg_glitch: got %0d expected %0d", sym_sel, o); end
    press_for(4'b1010, 12);
    run_len(o, n);
    checks++; if (sym_sel !== 4'd8) begin errors++; $display("FAIL mg_fb: got %0d expected 8", sym_sel); end
    checks++; if (score !== 3'd0) begin errors++; $display("FAIL mg_score: got %0d expected 0", score); end
    $display("test_multi_glitch: trial 0 orient %0d graded wrong", o);
    run_len(4'd8, n);
    for (int t = 1; t < 3; t++) begin
      wait_show(o, ok);
      checks++; if (!ok) begin errors++; $display("FAIL mg_show t=%0d: got timeout expected optotype", t); end
      press_for(btn_for(o), 12);
      run_len(o, n);
      checks++; if (sym_sel !== 4'd4 || score !== 3'(t)) begin errors++; $display("FAIL mg_trial t=%0d: got sym %0d score %0d expected sym 4 score %0d", t, sym_sel, score, t); end
      $display("test_multi_glitch: trial %0d orient %0d score %0d", t, o, score);
    end
    wait_done(n, ok);
    checks++; if (!ok || score !== 3'd2) begin errors++; $display("FAIL mg_done: got ok %0d score %0d expected ok 1 score 2", ok, score); end
    tick();
  endtask

  task automatic test_hold();
    logic [3:0] o;
    logic [3:0] o2;
    bit ok;
    int n;
    pulse_start();
    wait_show(o, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_show: got timeout expected optotype"); end
    btn = btn_for(o);
    repeat (12) tick();
    run_len(o, n);
    checks++; if (sym_sel !== 4'd4 || score !== 3'd1) begin errors++; $display("FAIL hold_fb1: got sym %0d score %0d expected sym 4 score 1", sym_sel, score); end
    btn = 4'b1111;
    run_len(4'd4, n);
    o2 = sym_sel;
    checks++; if (o2 > 4'd3) begin errors++; $display("FAIL hold_show2: got %0d expected 0..3", o2); end
    repeat (40) tick();
    checks++; if (sym_sel !== o2 || score !== 3'd1) begin errors++; $display("FAIL hold_held: got sym %0d score %0d expected sym %0d score 1", sym_sel, score, o2); end
    btn = 4'b0000;
    repeat (15) tick();
    checks++; if (sym_sel !== o2) begin errors++; $display("FAIL hold_release: got %0d expected %0d", sym_sel, o2); end
    press_for(btn_for(o2), 12);
    run_len(o2, n);
    checks++; if (sym_sel !== 4'd4 || score !== 3'd2) begin errors++; $display("FAIL hold_fb2: got sym %0d score %0d expected sym 4 score 2", sym_sel, score); end
    $display("test_hold: trial 1 orient %0d accepted after re-press", o2);
    wait_show(o, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_show3: got timeout expected optotype"); end
    press_for(btn_for(o), 12);
    wait_done(n, ok);
    checks++; if (!ok || score !== 3'd3) begin errors++; $display("FAIL hold_done: got ok %0d score %0d expected ok 1 score 3", ok, score); end
    tick();
  endtask

  task automatic test_abort();
    logic [3:0] o;
    bit ok;
    int n;
    int done_cnt;
    pulse_start();
    wait_show(o, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ab_show: got timeout expected optotype"); end
    pulse_start();
    checks++; if (busy !== 1'b1 || sym_sel !== o || score !== 3'd0) begin errors++; $display("FAIL ab_start1: got busy %0d sym %0d score %0d expected 1 %0d 0", busy, sym_sel, score, o); end
    press_for(btn_for(o), 12);
    run_len(o, n);
    checks++; if (sym_sel !== 4'd4 || score !== 3'd1) begin errors++; $display("FAIL ab_fb1: got sym %0d score %0d expected sym 4 score 1", sym_sel, score); end
    run_len(4'd4, n);
    wait_show(o, ok);
    pulse_start();
    checks++; if (score !== 3'd1 || sym_sel !== o) begin errors++; $display("FAIL ab_start2: got score %0d sym %0d expected score 1 sym %0d", score, sym_sel, o); end
    press_for(btn_for(o), 12);
    run_len(o, n);
    checks++; if (sym_sel !== 4'd4 || score !== 3'd2) begin errors++; $display("FAIL ab_fb2: got sym %0d score %0d expected sym 4 score 2", sym_sel, score); end
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    checks++; if (scan_idx !== 3'd0 || sym_sel !== 4'd8 || score !== 3'd0 || busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL ab_reset: got idx %0d sym %0d score %0d busy %0d done %0d expected 0 8 0 0 0", scan_idx, sym_sel, score, busy, done); end
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 0 || busy !== 1'b0 || sym_sel !== 4'd8) begin errors++; $display("FAIL ab_after: got done pulses %0d busy %0d sym %0d expected 0 0 8", done_cnt, busy, sym_sel); end
    $display("test_abort: reset in trial 1 feedback, done pulses %0d", done_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    btn   = 4'b0000;
    test_reset();
    test_correct();
    test_timeout();
    test_multi_glitch();
    test_hold();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish before 90000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
